// File: rtl/br_pkg.sv
// Shared types and defaults for the register-bank bulk sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package br_pkg;

    localparam int DW_DEF        = 32;
    localparam int AW_DEF        = 5;
    localparam int N_REGS_DEF    = 32;
    localparam int FIRST_REG_DEF = 0;

    // Encoded sequencer states; IDLE is the all-zero reset encoding.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_DUMP_RD  = 3'd2,
        S_DUMP_TX0 = 3'd3,
        S_DUMP_TX1 = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam int N_STATES = 6;

endpackage

// File: rtl/br_seq_skid.sv
// Two-entry holding buffer for one register pair read from the bank, streamed out as two beats.
// Latency: a capture is presented on valid/data/addr the cycle after load; second beat follows its handshake.
// Backpressure: valid/data/addr are held stable while ready is low; the buffer empties after the second handshake.
//
// Ports: load captures d0/d1 with beat address base; valid/data/addr/ready form the output stream.
module br_seq_skid
    import br_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [AW-1:0] base,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic [AW-1:0] addr
);

    // The output data register doubles as slot 0; only slot 1 needs its own storage.
    logic [DW-1:0] buf1;
    logic          ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            addr  <= '0;
            buf1  <= '0;
            ptr   <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d0;
            addr  <= base;
            buf1  <= d1;
            ptr   <= 1'b0;
        end else if (valid && ready) begin
            if (!ptr) begin
                data <= buf1;
                addr <= addr + AW'(1);
                ptr  <= 1'b1;
            end else begin
                // Data/addr keep their last value; only valid drops.
                valid <= 1'b0;
                ptr   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/br_seq.sv
// Bulk load/dump sequencer driving the read/write port of a register bank.
// Latency: load word written the cycle after its accept; dump beat pair 2 cycles after addresses are set.
// Backpressure: ld_ready is high throughout LOAD; dump beats hold until dp_ready.
//
// Ports: start_load/start_dump (IDLE only), ld_* load stream in, dp_* dump stream out,
// busy/done status, br_* drive the bank (Din, WA, RegWrite, RA1, RA2) and receive DR1/DR2.
module br_seq
    import br_pkg::*;
#(
    parameter int N_REGS    = N_REGS_DEF,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int FIRST_REG = FIRST_REG_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_load,
    input  logic          start_dump,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          dp_valid,
    output logic [DW-1:0] dp_data,
    output logic [AW-1:0] dp_addr,
    input  logic          dp_ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] br_din,
    output logic [AW-1:0] br_wa,
    output logic          br_regwrite,
    output logic [AW-1:0] br_ra1,
    output logic [AW-1:0] br_ra2,
    input  logic [DW-1:0] br_dr1,
    input  logic [DW-1:0] br_dr2
);

    // One extra index bit so FIRST_REG+N_REGS (e.g. 32) is representable.
    localparam int            IW        = AW + 1;
    localparam logic [IW-1:0] IDX_FIRST = IW'(FIRST_REG);
    localparam logic [IW-1:0] IDX_LAST  = IW'(FIRST_REG + N_REGS - 1);
    localparam logic [IW-1:0] IDX_END   = IW'(FIRST_REG + N_REGS);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic          accept;
    logic          dp_hs;
    logic          pair_last;
    logic          cap;

    assign accept    = (state == S_LOAD) && ld_valid;
    assign dp_hs     = dp_valid && dp_ready;
    assign pair_last = (idx + IW'(2)) == IDX_END;
    assign cap       = (state == S_DUMP_RD);

    assign ld_ready  = (state == S_LOAD);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // Load has priority; a simultaneous dump request is dropped.
                if (start_load) begin
                    state_nxt = S_LOAD;
                end else if (start_dump) begin
                    state_nxt = S_DUMP_RD;
                end
            end
            S_LOAD: begin
                if (accept && (idx == IDX_LAST)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DUMP_RD: begin
                state_nxt = S_DUMP_TX0;
            end
            S_DUMP_TX0: begin
                if (dp_hs) begin
                    state_nxt = S_DUMP_TX1;
                end
            end
            S_DUMP_TX1: begin
                if (dp_hs) begin
                    state_nxt = pair_last ? S_DONE : S_DUMP_RD;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= IDX_FIRST;
            br_regwrite <= 1'b0;
            br_wa       <= '0;
            br_din      <= '0;
            br_ra1      <= '0;
            br_ra2      <= '0;
            done        <= 1'b0;
        end else begin
            // Write enable is a single-cycle pulse per accepted word; WA/Din are
            // loaded on the same edge so they are stable for the whole pulse.
            br_regwrite <= accept;
            done        <= (state_nxt == S_DONE);

            if (accept) begin
                br_wa  <= idx[AW-1:0];
                br_din <= ld_data;
                idx    <= idx + IW'(1);
            end

            if (state == S_IDLE) begin
                if (start_load) begin
                    idx <= IDX_FIRST;
                end else if (start_dump) begin
                    idx    <= IDX_FIRST;
                    br_ra1 <= AW'(FIRST_REG);
                    br_ra2 <= AW'(FIRST_REG + 1);
                end
            end

            if ((state == S_DUMP_TX1) && dp_hs && !pair_last) begin
                idx    <= idx + IW'(2);
                br_ra1 <= br_ra1 + AW'(2);
                br_ra2 <= br_ra2 + AW'(2);
            end
        end
    end

    // Bank read data is combinational, so the pair is captured the cycle
    // after the read addresses were registered.
    br_seq_skid #(
        .DW(DW),
        .AW(AW)
    ) u_skid (
        .clk  (clk),
        .rst_n(rst_n),
        .load (cap),
        .d0   (br_dr1),
        .d1   (br_dr2),
        .base (idx[AW-1:0]),
        .ready(dp_ready),
        .valid(dp_valid),
        .data (dp_data),
        .addr (dp_addr)
    );

endmodule
